io_bus_ctrl: RTL and testbench

IO_BUS_CTRL -- requirements
Module: io_bus_ctrl

---
 rtl/io_bus_pkg.sv | 22 ++
 rtl/io_wait_ctrl.sv | 94 +++++++++
 rtl/io_bus_ctrl.sv | 135 +++++++++++++
 tb/tb_io_bus_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// Shared types and constants for the IO bus controller.
package io_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } io_state_e;

    // Control register addresses
    localparam logic [15:0] ADDR_BANK_LO = 16'h0000;
    localparam logic [15:0] ADDR_BANK_HI = 16'h0001;
    localparam logic [15:0] ADDR_ROM_CTL = 16'h0002;
    localparam logic [15:0] ADDR_STATUS  = 16'h0003;

    localparam logic [7:0]  DEFAULT_IO_PAGE = 8'hFE;
    localparam logic [7:0]  ROM_PAGE        = 8'hFF;
    localparam logic [15:0] ROM_WIN_LO      = 16'hE000;
    localparam logic [15:0] ROM_WIN_HI      = 16'hFDFF;
    localparam logic [7:0]  BUS_FILL        = 8'hFF;

endpackage

// File: rtl/io_wait_ctrl.sv
// Wait-state sequencer for banked IO accesses: stalls the CPU until the
// selected channel acks or the timeout counter expires, and latches the byte.
module io_wait_ctrl
    import io_bus_pkg::*;
#(
    parameter int unsigned NUM_CH  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [3:0]            ch_idx_i,
    input  logic [8*NUM_CH-1:0]   ch_data_i,
    input  logic [NUM_CH-1:0]     ch_ack_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  tmo_err_o,
    output logic [NUM_CH-1:0]     ch_cs_o,
    output logic [7:0]            data_o
);

    io_state_e           state_q;
    logic [7:0]          cnt_q;
    logic [3:0]          idx_q;
    logic [7:0]          data_q;
    logic [NUM_CH-1:0]   cs_q;
    logic [NUM_CH-1:0]   onehot;
    logic                ack_sel;
    logic [7:0]          data_sel;
    logic                tmo_hit;

    // Select ack/data of the latched channel and build the start one-hot
    always_comb begin
        ack_sel  = 1'b0;
        data_sel = BUS_FILL;
        onehot   = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            onehot[c] = (ch_idx_i == 4'(c));
            if (idx_q == 4'(c)) begin
                ack_sel  = ch_ack_i[c];
                data_sel = ch_data_i[8*c +: 8];
            end
        end
        tmo_hit = (state_q == ST_WAIT) && !ack_sel && (cnt_q == 8'(TIMEOUT));
    end

    // FSM, wait counter, channel select and data latch
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= BUS_FILL;
            cs_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= '0;
                        idx_q   <= ch_idx_i;
                        cs_q    <= onehot;
                    end
                end
                ST_WAIT: begin
                    if (ack_sel) begin
                        data_q  <= data_sel;
                        cs_q    <= '0;
                        state_q <= ST_DONE;
                    end else if (cnt_q == 8'(TIMEOUT)) begin
                        data_q  <= BUS_FILL;
                        cs_q    <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: begin
                    state_q <= ST_IDLE;
                    cs_q    <= '0;
                end
            endcase
        end
    end

    // Stall starts combinationally in the request cycle
    assign busy_o    = ((state_q == ST_IDLE) && start_i) || (state_q == ST_WAIT);
    assign done_o    = (state_q == ST_DONE);
    assign tmo_err_o = tmo_hit;
    assign ch_cs_o   = cs_q;
    assign data_o    = data_q;

endmodule

// File: rtl/io_bus_ctrl.sv
// CPU bus controller: address decode, control registers, read mux and
// banked IO wait-state handling.
module io_bus_ctrl
    import io_bus_pkg::*;
#(
    parameter int unsigned NUM_CH  = 8,
    parameter logic [7:0]  IO_PAGE = DEFAULT_IO_PAGE,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [15:0]           addr_i,
    input  logic [7:0]            data_i,
    input  logic                  R_W_n,
    output logic [7:0]            data_o,
    output logic                  rdy_o,
    output logic                  ram_cs_o,
    input  logic [7:0]            ram_data_i,
    output logic                  rom_cs_o,
    input  logic [7:0]            rom_data_i,
    output logic [NUM_CH-1:0]     ch_cs_o,
    input  logic [8*NUM_CH-1:0]   ch_data_i,
    input  logic [NUM_CH-1:0]     ch_ack_i,
    output logic                  bus_err_o
);

    logic [7:0]  bank_lo_q;
    logic [7:0]  bank_hi_q;
    logic        rom_ctl_q;
    logic        bus_err_q;
    logic [15:0] bank;
    logic        bank_ok;
    logic        sel_ctl;
    logic        sel_rom;
    logic        sel_ram;
    logic        sel_io;
    logic        io_start;
    logic        io_unmapped;
    logic        busy;
    logic        done;
    logic        tmo_err;
    logic [7:0]  io_data;

    assign bank    = {bank_hi_q, bank_lo_q};
    assign bank_ok = (bank < 16'(NUM_CH));

    // Prioritised address decode
    always_comb begin
        sel_ctl = 1'b0;
        sel_rom = 1'b0;
        sel_ram = 1'b0;
        sel_io  = 1'b0;
        if (addr_i[15:2] == ADDR_BANK_LO[15:2])
            sel_ctl = 1'b1;
        else if (addr_i[15:8] == ROM_PAGE)
            sel_rom = 1'b1;
        else if (addr_i[15:8] == IO_PAGE)
            sel_io = 1'b1;
        else if ((addr_i >= ROM_WIN_LO) && (addr_i <= ROM_WIN_HI)) begin
            sel_rom = !rom_ctl_q;
            sel_ram = rom_ctl_q;
        end else
            sel_ram = 1'b1;
    end

    // Start is qualified by reset so a held IO address cannot pull rdy_o low
    // while the controller is being reset
    assign io_start    = rst_n_i && sel_io && bank_ok;
    assign io_unmapped = sel_io && !bank_ok;

    io_wait_ctrl #(
        .NUM_CH  (NUM_CH),
        .TIMEOUT (TIMEOUT)
    ) u_wait (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .start_i   (io_start),
        .ch_idx_i  (bank[3:0]),
        .ch_data_i (ch_data_i),
        .ch_ack_i  (ch_ack_i),
        .busy_o    (busy),
        .done_o    (done),
        .tmo_err_o (tmo_err),
        .ch_cs_o   (ch_cs_o),
        .data_o    (io_data)
    );

    // Control registers; a bus-error set beats a same-cycle status clear
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bank_lo_q <= '0;
            bank_hi_q <= '0;
            rom_ctl_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            if (sel_ctl && !R_W_n) begin
                case (addr_i)
                    ADDR_BANK_LO: bank_lo_q <= data_i;
                    ADDR_BANK_HI: bank_hi_q <= data_i;
                    ADDR_ROM_CTL: rom_ctl_q <= data_i[0];
                    ADDR_STATUS:  if (data_i[0]) bus_err_q <= 1'b0;
                    default: ;
                endcase
            end
            if (io_unmapped || tmo_err)
                bus_err_q <= 1'b1;
        end
    end

    // Read data mux; an IO access in progress echoes the CPU data bus
    always_comb begin
        data_o = data_i;
        if (done)
            data_o = io_data;
        else if (sel_ctl) begin
            case (addr_i[1:0])
                2'd0:    data_o = bank_lo_q;
                2'd1:    data_o = bank_hi_q;
                2'd2:    data_o = {7'd0, rom_ctl_q};
                default: data_o = {7'd0, bus_err_q};
            endcase
        end else if (sel_rom)
            data_o = rom_data_i;
        else if (sel_ram)
            data_o = ram_data_i;
        else if (io_unmapped)
            data_o = BUS_FILL;
    end

    assign rdy_o     = !busy;
    assign ram_cs_o  = sel_ram;
    assign rom_cs_o  = sel_rom;
    assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed bench for io_bus_ctrl.
module tb_io_bus_ctrl;

    localparam int unsigned NUM_CH  = 8;
    localparam int unsigned TIMEOUT = 15;

    logic                clk_i = 1'b0;
    logic                rst_n_i;
    logic [15:0]         addr_i;
    logic [7:0]          data_i;
    logic                R_W_n;
    logic [7:0]          data_o;
    logic                rdy_o;
    logic                ram_cs_o;
    logic [7:0]          ram_data_i;
    logic                rom_cs_o;
    logic [7:0]          rom_data_i;
    logic [NUM_CH-1:0]   ch_cs_o;
    logic [8*NUM_CH-1:0] ch_data_i;
    logic [NUM_CH-1:0]   ch_ack_i;
    logic                bus_err_o;

    int n_checks = 0;
    int n_pass   = 0;

    io_bus_ctrl #(
        .NUM_CH  (NUM_CH),
        .IO_PAGE (8'hFE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .R_W_n      (R_W_n),
        .data_o     (data_o),
        .rdy_o      (rdy_o),
        .ram_cs_o   (ram_cs_o),
        .ram_data_i (ram_data_i),
        .rom_cs_o   (rom_cs_o),
        .rom_data_i (rom_data_i),
        .ch_cs_o    (ch_cs_o),
        .ch_data_i  (ch_data_i),
        .ch_ack_i   (ch_ack_i),
        .bus_err_o  (bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_bus();
        addr_i = 16'h1000;
        data_i = 8'h00;
        R_W_n  = 1'b1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        addr_i = a;
        data_i = d;
        R_W_n  = 1'b0;
        step();
        idle_bus();
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        #3;
        n_checks++; if (rdy_o !== 1'b1) $display("FAIL rst_rdy: got %b want 1", rdy_o); else n_pass++;
        n_checks++; if (ch_cs_o !== 8'h00) $display("FAIL rst_cs: got %h want 00", ch_cs_o); else n_pass++;
        n_checks++; if (bus_err_o !== 1'b0) $display("FAIL rst_err: got %b want 0", bus_err_o); else n_pass++;
        @(negedge clk_i); @(negedge clk_i);
        rst_n_i = 1'b1;
        step();
        addr_i = 16'h0002; #1;
        n_checks++; if (data_o !== 8'h00) $display("FAIL rst_romctl: got %h want 00", data_o); else n_pass++;
        idle_bus();
    endtask

    task automatic test_ch_ack();
        cpu_write(16'h0000, 8'h02);
        addr_i = 16'hFE10; R_W_n = 1'b1; ch_ack_i = 8'h04;
        @(negedge clk_i);
        n_checks++; if (rdy_o !== 1'b0) $display("FAIL ack_c0_rdy: got %b want 0", rdy_o); else n_pass++;
        n_checks++; if (ch_cs_o !== 8'h00) $display("FAIL ack_c0_cs: got %h want 00", ch_cs_o); else n_pass++;
        step();
        @(negedge clk_i);
        n_checks++; if (rdy_o !== 1'b0) $display("FAIL ack_c1_rdy: got %b want 0", rdy_o); else n_pass++;
        n_checks++; if (ch_cs_o !== 8'h04) $display("FAIL ack_c1_cs: got %h want 04", ch_cs_o); else n_pass++;
        step();
        @(negedge clk_i);
        n_checks++; if (rdy_o !== 1'b1) $display("FAIL ack_c2_rdy: got %b want 1", rdy_o); else n_pass++;
        n_checks++; if (ch_cs_o !== 8'h00) $display("FAIL ack_c2_cs: got %h want 00", ch_cs_o); else n_pass++;
        n_checks++; if (data_o !== 8'hA2) $display("FAIL ack_data: got %h want a2", data_o); else n_pass++;
        n_checks++; if (bus_err_o !== 1'b0) $display("FAIL ack_err: got %b want 0", bus_err_o); else n_pass++;
        step();
        idle_bus(); ch_ack_i = '0;
    endtask

    task automatic test_timeout();
        int cnt;
        cpu_write(16'h0000, 8'h01);
        addr_i = 16'hFE20; R_W_n = 1'b1; ch_ack_i = '0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (rdy_o) break;
            cnt++;
            step();
        end
        n_checks++; if (cnt !== int'(TIMEOUT + 2)) $display("FAIL tmo_stall: got %0d want %0d", cnt, TIMEOUT + 2); else n_pass++;
        n_checks++; if (data_o !== 8'hFF) $display("FAIL tmo_data: got %h want ff", data_o); else n_pass++;
        n_checks++; if (bus_err_o !== 1'b1) $display("FAIL tmo_err: got %b want 1", bus_err_o); else n_pass++;
        step();
        idle_bus();
        cpu_write(16'h0003, 8'h01);
        @(negedge clk_i);
        n_checks++; if (bus_err_o !== 1'b0) $display("FAIL tmo_clear: got %b want 0", bus_err_o); else n_pass++;
        step();
    endtask

    task automatic test_rom_ram();
        cpu_write(16'h0002, 8'h00);
        addr_i = 16'hE123; #1;
        n_checks++; if ({rom_cs_o, ram_cs_o} !== 2'b10) $display("FAIL win_rom_cs: got %b want 10", {rom_cs_o, ram_cs_o}); else n_pass++;
        n_checks++; if (data_o !== 8'hC3) $display("FAIL win_rom_data: got %h want c3", data_o); else n_pass++;
        addr_i = 16'hDFFF; #1;
        n_checks++; if ({rom_cs_o, ram_cs_o} !== 2'b01) $display("FAIL below_win_cs: got %b want 01", {rom_cs_o, ram_cs_o}); else n_pass++;
        addr_i = 16'hFFFC; #1;
        n_checks++; if (rom_cs_o !== 1'b1) $display("FAIL top_rom0_cs: got %b want 1", rom_cs_o); else n_pass++;
        idle_bus();
        cpu_write(16'h0002, 8'h01);
        addr_i = 16'hE123; #1;
        n_checks++; if ({rom_cs_o, ram_cs_o} !== 2'b01) $display("FAIL win_ram_cs: got %b want 01", {rom_cs_o, ram_cs_o}); else n_pass++;
        n_checks++; if (data_o !== 8'h5A) $display("FAIL win_ram_data: got %h want 5a", data_o); else n_pass++;
        addr_i = 16'hFFFC; #1;
        n_checks++; if (rom_cs_o !== 1'b1) $display("FAIL top_rom1_cs: got %b want 1", rom_cs_o); else n_pass++;
        addr_i = 16'h0002; #1;
        n_checks++; if (data_o !== 8'h01) $display("FAIL romctl_rd: got %h want 01", data_o); else n_pass++;
        idle_bus();
        cpu_write(16'h0002, 8'h00);
    endtask

    task automatic test_unmapped();
        cpu_write(16'h0000, 8'(NUM_CH));
        addr_i = 16'hFE00; R_W_n = 1'b1;
        @(negedge clk_i);
        n_checks++; if (data_o !== 8'hFF) $display("FAIL unm_data: got %h want ff", data_o); else n_pass++;
        n_checks++; if (rdy_o !== 1'b1) $display("FAIL unm_rdy: got %b want 1", rdy_o); else n_pass++;
        n_checks++; if (ch_cs_o !== 8'h00) $display("FAIL unm_cs: got %h want 00", ch_cs_o); else n_pass++;
        step();
        @(negedge clk_i);
        n_checks++; if (bus_err_o !== 1'b1) $display("FAIL unm_err: got %b want 1", bus_err_o); else n_pass++;
        n_checks++; if (rdy_o !== 1'b1) $display("FAIL unm_rdy2: got %b want 1", rdy_o); else n_pass++;
        step();
        idle_bus();
        cpu_write(16'h0003, 8'h01);
    endtask

    task automatic test_reset_mid_wait();
        cpu_write(16'h0000, 8'h03);
        cpu_write(16'h0002, 8'h01);
        addr_i = 16'hFE00; R_W_n = 1'b1; ch_ack_i = '0;
        step(); step();
        @(negedge clk_i);
        n_checks++; if (ch_cs_o !== 8'h08) $display("FAIL mid_cs: got %h want 08", ch_cs_o); else n_pass++;
        #2;
        rst_n_i = 1'b0;
        #1;
        n_checks++; if (rdy_o !== 1'b1) $display("FAIL rstw_rdy: got %b want 1", rdy_o); else n_pass++;
        n_checks++; if (ch_cs_o !== 8'h00) $display("FAIL rstw_cs: got %h want 00", ch_cs_o); else n_pass++;
        step();
        idle_bus();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        step(); step();
        addr_i = 16'h0000; #1;
        n_checks++; if (data_o !== 8'h00) $display("FAIL rstw_lo: got %h want 00", data_o); else n_pass++;
        addr_i = 16'h0001; #1;
        n_checks++; if (data_o !== 8'h00) $display("FAIL rstw_hi: got %h want 00", data_o); else n_pass++;
        addr_i = 16'h0002; #1;
        n_checks++; if (data_o !== 8'h00) $display("FAIL rstw_romctl: got %h want 00", data_o); else n_pass++;
        addr_i = 16'h0003; #1;
        n_checks++; if (data_o !== 8'h00) $display("FAIL rstw_status: got %h want 00", data_o); else n_pass++;
        idle_bus();
    endtask

    task automatic test_err_race();
        cpu_write(16'h0000, 8'h01);
        addr_i = 16'hFE30; R_W_n = 1'b1; ch_ack_i = '0;
        for (int i = 0; i < int'(TIMEOUT + 1); i++) step();
        // last WAIT cycle: a status-clear write collides with the timeout
        addr_i = 16'h0003; data_i = 8'h01; R_W_n = 1'b0;
        @(negedge clk_i);
        n_checks++; if (rdy_o !== 1'b0) $display("FAIL race_rdy: got %b want 0", rdy_o); else n_pass++;
        step();
        idle_bus();
        @(negedge clk_i);
        n_checks++; if (bus_err_o !== 1'b1) $display("FAIL race_err: got %b want 1", bus_err_o); else n_pass++;
        step();
        cpu_write(16'h0003, 8'h01);
        @(negedge clk_i);
        n_checks++; if (bus_err_o !== 1'b0) $display("FAIL race_clear: got %b want 0", bus_err_o); else n_pass++;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        idle_bus();
        ch_ack_i   = '0;
        ram_data_i = 8'h5A;
        rom_data_i = 8'hC3;
        for (int n = 0; n < int'(NUM_CH); n++) ch_data_i[8*n +: 8] = 8'hA0 + 8'(n);
        test_reset();
        test_ch_ack();
        test_timeout();
        test_rom_ram();
        test_unmapped();
        test_reset_mid_wait();
        test_err_race();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
